// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the Simple RISC-V multi-cycle control path:
// FSM states, major opcodes and the ALUOp codes handed to the ALU control decoder.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd7
    } ctrl_state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_IALU) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter: increments when en_i is high,
// wraps modulo 2^CNT_W, cleared asynchronously by rst_ni.
module retire_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/multicycle_main_controller.sv
// Multi-cycle main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes from the current state and latched opcode, and counts retirements.
module multicycle_main_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             funct7_mask,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    ctrl_state_e state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic        illegal_q, illegal_d;
    logic        retire;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        retire    = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                op_d    = opcode;
                state_d = is_legal_op(opcode) ? StExec : StTrap;
            end
            StExec: begin
                if (op_q == OP_BRANCH) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (is_mem_op(op_q)) begin
                    state_d = StMem;
                end else if ((op_q == OP_RTYPE) || (op_q == OP_IALU)) begin
                    state_d = StWb;
                end else begin
                    state_d = StTrap;
                end
            end
            StMem: begin
                if (mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flag is sticky from the edge that enters TRAP until reset.
        if (state_d == StTrap) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Decoded from state_q so reset drops every strobe without waiting for a clock.
    always_comb begin
        mem_req     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_op      = ALUOP_ADD;
        alu_src     = 1'b0;
        funct7_mask = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            StExec: begin
                if (op_q == OP_RTYPE) begin
                    alu_op = ALUOP_FUNCT;
                end else if (op_q == OP_IALU) begin
                    alu_op      = ALUOP_FUNCT;
                    alu_src     = 1'b1;
                    funct7_mask = 1'b1;
                end else if (is_mem_op(op_q)) begin
                    alu_src = 1'b1;
                end else if (op_q == OP_BRANCH) begin
                    alu_op   = ALUOP_BEQ;
                    pc_src   = 1'b1;
                    pc_write = zero;
                end
            end
            StMem: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_read  = (op_q == OP_LOAD);
                mem_write = (op_q == OP_STORE);
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LOAD);
            end
            default: begin
            end
        endcase
    end

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (retire),
        .count_o(instr_count)
    );

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller; a second 2-bit-counter instance
// shares the stimulus so counter wrap is reached in a few retirements.
module tb_multicycle_main_controller;

    localparam logic [12:0] SB_NONE   = 13'b0_0_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] SB_FW     = 13'b1_1_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] SB_FR     = 13'b1_1_0_0_1_1_0_00_0_0_0_0;
    localparam logic [12:0] SB_EX_R   = 13'b0_0_0_0_0_0_0_10_0_0_0_0;
    localparam logic [12:0] SB_EX_I   = 13'b0_0_0_0_0_0_0_10_1_1_0_0;
    localparam logic [12:0] SB_EX_M   = 13'b0_0_0_0_0_0_0_00_1_0_0_0;
    localparam logic [12:0] SB_EX_B1  = 13'b0_0_0_0_0_1_1_01_0_0_0_0;
    localparam logic [12:0] SB_EX_B0  = 13'b0_0_0_0_0_0_1_01_0_0_0_0;
    localparam logic [12:0] SB_MEM_LW = 13'b1_1_0_1_0_0_0_00_0_0_0_0;
    localparam logic [12:0] SB_MEM_SW = 13'b1_0_1_1_0_0_0_00_0_0_0_0;
    localparam logic [12:0] SB_WB_ALU = 13'b0_0_0_0_0_0_0_00_0_0_1_0;
    localparam logic [12:0] SB_WB_LW  = 13'b0_0_0_0_0_0_0_00_0_0_1_1;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src;
    logic [1:0]  alu_op;
    logic        alu_src, funct7_mask, reg_write, mem_to_reg;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] instr_count;

    logic        w_mem_req, w_mem_read, w_mem_write, w_iord, w_ir_write, w_pc_write, w_pc_src;
    logic [1:0]  w_alu_op;
    logic        w_alu_src, w_funct7_mask, w_reg_write, w_mem_to_reg;
    logic [2:0]  w_state;
    logic        w_illegal;
    logic [1:0]  w_instr_count;

    logic [12:0] strb;
    assign strb = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
                   alu_op, alu_src, funct7_mask, reg_write, mem_to_reg};

    int n_cmp;
    int n_err;

    multicycle_main_controller #(.CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
        .alu_src(alu_src), .funct7_mask(funct7_mask), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal), .instr_count(instr_count)
    );

    multicycle_main_controller #(.CNT_W(2)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(w_mem_req), .mem_read(w_mem_read), .mem_write(w_mem_write), .iord(w_iord),
        .ir_write(w_ir_write), .pc_write(w_pc_write), .pc_src(w_pc_src), .alu_op(w_alu_op),
        .alu_src(w_alu_src), .funct7_mask(w_funct7_mask), .reg_write(w_reg_write),
        .mem_to_reg(w_mem_to_reg), .state(w_state), .illegal(w_illegal),
        .instr_count(w_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then sample once they have settled.
    task automatic drive_cycle(input logic rdy, input logic z,
                               output logic [2:0] st, output logic [12:0] sb);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        #1;
        st = state;
        sb = strb;
    endtask

    // Row layout: {mem_ready, zero, expected state[2:0], expected strobes[12:0]}.
    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({state, strb} !== {3'd0, SB_NONE}) begin
            n_err++;
            $display("FAIL reset_outputs: state=%0d strb=%b, expected state=0 strb=%b",
                     state, strb, SB_NONE);
        end
        n_cmp++;
        if ({illegal, instr_count, w_instr_count} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_regs: illegal=%b count=%0d wcount=%0d, expected 0/0/0",
                     illegal, instr_count, w_instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        logic [17:0] rows [$];
        logic [2:0]  st;
        logic [12:0] sb;
        opcode = 7'b0110011;
        rows = '{{2'b10, 3'd1, SB_FR}, {2'b10, 3'd2, SB_NONE}, {2'b10, 3'd3, SB_EX_R},
                 {2'b10, 3'd5, SB_WB_ALU}, {2'b00, 3'd1, SB_FW}};
        for (int i = 0; i < rows.size(); i++) begin
            drive_cycle(rows[i][17], rows[i][16], st, sb);
            n_cmp++;
            if ({st, sb} !== rows[i][15:0]) begin
                n_err++;
                $display("FAIL rtype row %0d: state=%0d strb=%b, expected state=%0d strb=%b",
                         i, st, sb, rows[i][15:13], rows[i][12:0]);
            end
        end
        n_cmp++;
        if ({instr_count, w_instr_count} !== {32'd1, 2'd1}) begin
            n_err++;
            $display("FAIL rtype_count: count=%0d wcount=%0d, expected 1/1",
                     instr_count, w_instr_count);
        end
    endtask

    task automatic test_load_wait();
        logic [17:0] rows [$];
        logic [2:0]  st;
        logic [12:0] sb;
        opcode = 7'b0000011;
        rows = '{{2'b10, 3'd1, SB_FR}, {2'b00, 3'd2, SB_NONE}, {2'b00, 3'd3, SB_EX_M},
                 {2'b00, 3'd4, SB_MEM_LW}, {2'b00, 3'd4, SB_MEM_LW}, {2'b10, 3'd4, SB_MEM_LW},
                 {2'b10, 3'd5, SB_WB_LW}, {2'b00, 3'd1, SB_FW}};
        for (int i = 0; i < rows.size(); i++) begin
            drive_cycle(rows[i][17], rows[i][16], st, sb);
            n_cmp++;
            if ({st, sb} !== rows[i][15:0]) begin
                n_err++;
                $display("FAIL load row %0d: state=%0d strb=%b, expected state=%0d strb=%b",
                         i, st, sb, rows[i][15:13], rows[i][12:0]);
            end
        end
        n_cmp++;
        if ({instr_count, w_instr_count} !== {32'd2, 2'd2}) begin
            n_err++;
            $display("FAIL load_count: count=%0d wcount=%0d, expected 2/2",
                     instr_count, w_instr_count);
        end
    endtask

    task automatic test_store_branch();
        logic [17:0] rows [$];
        logic [6:0]  ops  [$];
        logic [2:0]  st;
        logic [12:0] sb;
        logic [31:0] exp_cnt;
        // SW, BEQ taken, BEQ not taken: counter passes 3 (all ones in 2 bits) then wraps.
        rows = '{{2'b10, 3'd1, SB_FR}, {2'b10, 3'd2, SB_NONE}, {2'b00, 3'd3, SB_EX_M},
                 {2'b10, 3'd4, SB_MEM_SW}, {2'b00, 3'd1, SB_FW},
                 {2'b10, 3'd1, SB_FR}, {2'b10, 3'd2, SB_NONE}, {2'b01, 3'd3, SB_EX_B1},
                 {2'b00, 3'd1, SB_FW},
                 {2'b10, 3'd1, SB_FR}, {2'b11, 3'd2, SB_NONE}, {2'b10, 3'd3, SB_EX_B0},
                 {2'b00, 3'd1, SB_FW}};
        ops = '{7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011,
                7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011,
                7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011};
        exp_cnt = 32'd2;
        for (int i = 0; i < rows.size(); i++) begin
            opcode = ops[i];
            drive_cycle(rows[i][17], rows[i][16], st, sb);
            n_cmp++;
            if ({st, sb} !== rows[i][15:0]) begin
                n_err++;
                $display("FAIL st_br row %0d: state=%0d strb=%b, expected state=%0d strb=%b",
                         i, st, sb, rows[i][15:13], rows[i][12:0]);
            end
            if (i == 4 || i == 8 || i == 12) begin
                exp_cnt = exp_cnt + 32'd1;
                n_cmp++;
                if ({instr_count, w_instr_count} !== {exp_cnt, exp_cnt[1:0]}) begin
                    n_err++;
                    $display("FAIL st_br_count row %0d: count=%0d wcount=%0d, expected %0d/%0d",
                             i, instr_count, w_instr_count, exp_cnt, exp_cnt[1:0]);
                end
            end
        end
    endtask

    task automatic test_ialu();
        logic [17:0] rows [$];
        logic [2:0]  st;
        logic [12:0] sb;
        opcode = 7'b0010011;
        rows = '{{2'b10, 3'd1, SB_FR}, {2'b10, 3'd2, SB_NONE}, {2'b10, 3'd3, SB_EX_I},
                 {2'b10, 3'd5, SB_WB_ALU}, {2'b00, 3'd1, SB_FW}};
        for (int i = 0; i < rows.size(); i++) begin
            drive_cycle(rows[i][17], rows[i][16], st, sb);
            n_cmp++;
            if ({st, sb} !== rows[i][15:0]) begin
                n_err++;
                $display("FAIL ialu row %0d: state=%0d strb=%b, expected state=%0d strb=%b",
                         i, st, sb, rows[i][15:13], rows[i][12:0]);
            end
        end
        n_cmp++;
        if ({instr_count, w_instr_count} !== {32'd6, 2'd2}) begin
            n_err++;
            $display("FAIL ialu_count: count=%0d wcount=%0d, expected 6/2",
                     instr_count, w_instr_count);
        end
    endtask

    task automatic test_trap();
        logic [2:0]  st;
        logic [12:0] sb;
        opcode = 7'b1111111;
        drive_cycle(1'b1, 1'b0, st, sb);
        drive_cycle(1'b1, 1'b1, st, sb);
        n_cmp++;
        if ({st, sb, illegal} !== {3'd2, SB_NONE, 1'b0}) begin
            n_err++;
            $display("FAIL trap_decode: state=%0d strb=%b illegal=%b, expected 2/%b/0",
                     st, sb, illegal, SB_NONE);
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(i[0], i[1], st, sb);
            n_cmp++;
            if ({st, sb, illegal} !== {3'd7, SB_NONE, 1'b1}) begin
                n_err++;
                $display("FAIL trap_hold cyc %0d: state=%0d strb=%b illegal=%b, expected 7/%b/1",
                         i, st, sb, illegal, SB_NONE);
            end
        end
        n_cmp++;
        if (instr_count !== 32'd6) begin
            n_err++;
            $display("FAIL trap_count: count=%0d, expected 6", instr_count);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({state, illegal, instr_count} !== {3'd0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL trap_reset: state=%0d illegal=%b count=%0d, expected 0/0/0",
                     state, illegal, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        logic [2:0]  st;
        logic [12:0] sb;
        opcode = 7'b0000011;
        drive_cycle(1'b0, 1'b0, st, sb);
        drive_cycle(1'b1, 1'b0, st, sb);
        drive_cycle(1'b0, 1'b0, st, sb);
        drive_cycle(1'b0, 1'b0, st, sb);
        drive_cycle(1'b0, 1'b0, st, sb);
        n_cmp++;
        if ({st, sb} !== {3'd4, SB_MEM_LW}) begin
            n_err++;
            $display("FAIL mid_mem_pre: state=%0d strb=%b, expected state=4 strb=%b",
                     st, sb, SB_MEM_LW);
        end
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({state, mem_req} !== {3'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_mem_async: state=%0d mem_req=%b, expected 0/0", state, mem_req);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({state, strb, instr_count} !== {3'd0, SB_NONE, 32'd0}) begin
            n_err++;
            $display("FAIL mid_mem_held: state=%0d strb=%b count=%0d, expected 0/%b/0",
                     state, strb, instr_count, SB_NONE);
        end
        rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, st, sb);
        n_cmp++;
        if ({st, sb, instr_count} !== {3'd1, SB_FW, 32'd0}) begin
            n_err++;
            $display("FAIL mid_mem_restart: state=%0d strb=%b count=%0d, expected 1/%b/0",
                     st, sb, instr_count, SB_FW);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        opcode    = 7'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_branch();
        test_ialu();
        test_trap();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
